// File: rtl/alu128_rr_scheduler.sv
// Round-robin issue/writeback sequencer that shares one 128-bit ALU between two requesters.
// The combinational ALU (alu_128bitex) is defined here and instantiated by the scheduler.
module alu_128bitex #(
  parameter int LENGTH = 128
) (
  input  logic [LENGTH-1:0] op1_i,
  input  logic [LENGTH-1:0] op2_i,
  input  logic              mode_i,
  input  logic [2:0]        operation_i,
  output logic [LENGTH-1:0] out_o,
  output logic              carry_o,
  output logic              zero_o,
  output logic              sign_o,
  output logic              overflow_o
);
  localparam int M = LENGTH - 1;
  logic [LENGTH:0] sum_s;

  // Result and flags; carry/overflow are only meaningful in arithmetic mode
  always_comb begin
    sum_s      = '0;
    out_o      = '0;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    if (mode_i) begin
      case (operation_i)
        3'b000: begin
          sum_s      = {1'b0, op1_i} + {1'b0, op2_i};
          out_o      = sum_s[M:0];
          carry_o    = sum_s[LENGTH];
          overflow_o = (op1_i[M] == op2_i[M]) && (sum_s[M] != op1_i[M]);
        end
        3'b001: begin
          sum_s      = {1'b0, op1_i} - {1'b0, op2_i};
          out_o      = sum_s[M:0];
          carry_o    = sum_s[LENGTH];
          overflow_o = (op1_i[M] != op2_i[M]) && (sum_s[M] != op1_i[M]);
        end
        3'b010: begin
          sum_s      = {1'b0, op1_i} + {{LENGTH{1'b0}}, 1'b1};
          out_o      = sum_s[M:0];
          carry_o    = sum_s[LENGTH];
          overflow_o = ~op1_i[M] & sum_s[M];
        end
        3'b011: begin
          sum_s      = {1'b0, op1_i} - {{LENGTH{1'b0}}, 1'b1};
          out_o      = sum_s[M:0];
          carry_o    = sum_s[LENGTH];
          overflow_o = op1_i[M] & ~sum_s[M];
        end
        3'b100: begin
          out_o   = {1'b0, op1_i[M:1]};
          carry_o = op1_i[0];
        end
        3'b101: begin
          // Shift left: the bit shifted out of the MSB becomes carry
          out_o   = {op1_i[M-1:0], 1'b0};
          carry_o = op1_i[M];
        end
        3'b110: begin
          out_o   = {op1_i[M], op1_i[M:1]};
          carry_o = op1_i[0];
        end
        3'b111: out_o = op1_i;
        default: out_o = '0;
      endcase
    end else begin
      case (operation_i)
        3'b000:  out_o = op1_i & op2_i;
        3'b001:  out_o = op1_i | op2_i;
        3'b010:  out_o = op1_i ^ op2_i;
        3'b011:  out_o = ~(op1_i | op2_i);
        3'b100:  out_o = ~(op1_i & op2_i);
        3'b101:  out_o = ~(op1_i ^ op2_i);
        3'b110:  out_o = ~op1_i;
        3'b111:  out_o = op1_i;
        default: out_o = '0;
      endcase
    end
    zero_o = (out_o == '0);
    sign_o = out_o[M];
  end
endmodule

module alu128_rr_scheduler #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic             req0_mode,
  input  logic [2:0]       req0_operation,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic             req1_mode,
  input  logic [2:0]       req1_operation,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_out,
  output logic [3:0]       resp_flags,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
  logic             mode_q, mode_d;
  logic [2:0]       opr_q, opr_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] resp_out_q, resp_out_d;
  logic [3:0]       resp_flags_q, resp_flags_d;
  logic             resp_id_q, resp_id_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic [WIDTH-1:0] alu_out_s;
  logic             alu_c_s, alu_z_s, alu_s_s, alu_v_s;
  logic             gnt_id_s, accept_s, hshake_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  alu_128bitex #(.LENGTH(WIDTH)) u_alu (
    .op1_i(op1_q), .op2_i(op2_q), .mode_i(mode_q), .operation_i(opr_q),
    .out_o(alu_out_s), .carry_o(alu_c_s), .zero_o(alu_z_s),
    .sign_o(alu_s_s), .overflow_o(alu_v_s)
  );

  // Arbitration, next-state and datapath-load decisions
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    mode_d       = mode_q;
    opr_d        = opr_q;
    id_d         = id_q;
    resp_out_d   = resp_out_q;
    resp_flags_d = resp_flags_q;
    resp_id_d    = resp_id_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    req_ready    = 2'b00;

    // With both valid the winner is the one not granted last time
    gnt_id_s = (req_valid == 2'b11) ? ~last_grant_q : ~req_valid[0];
    hshake_s = (state_q == S_RESP) && resp_ready;
    accept_s = !rst && (req_valid != 2'b00) && ((state_q == S_IDLE) || hshake_s);

    case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_EXEC: begin
        resp_out_d   = alu_out_s;
        resp_flags_d = {alu_c_s, alu_z_s, alu_s_s, alu_v_s};
        resp_id_d    = id_q;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (hshake_s) begin
          state_d = S_IDLE;
          if (resp_id_q) begin
            cnt1_d = sat_inc(cnt1_q);
          end else begin
            cnt0_d = sat_inc(cnt0_q);
          end
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept_s) begin
      req_ready    = gnt_id_s ? 2'b10 : 2'b01;
      last_grant_d = gnt_id_s;
      id_d         = gnt_id_s;
      op1_d        = gnt_id_s ? req1_op1 : req0_op1;
      op2_d        = gnt_id_s ? req1_op2 : req0_op2;
      mode_d       = gnt_id_s ? req1_mode : req0_mode;
      opr_d        = gnt_id_s ? req1_operation : req0_operation;
      state_d      = S_EXEC;
    end else begin
      req_ready = 2'b00;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      op1_q        <= '0;
      op2_q        <= '0;
      mode_q       <= 1'b0;
      opr_q        <= 3'b000;
      id_q         <= 1'b0;
      resp_out_q   <= '0;
      resp_flags_q <= 4'b0000;
      resp_id_q    <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      mode_q       <= mode_d;
      opr_q        <= opr_d;
      id_q         <= id_d;
      resp_out_q   <= resp_out_d;
      resp_flags_q <= resp_flags_d;
      resp_id_q    <= resp_id_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign resp_valid = (state_q == S_RESP);
  assign resp_id    = resp_id_q;
  assign resp_out   = resp_out_q;
  assign resp_flags = resp_flags_q;
  assign done_cnt0  = cnt0_q;
  assign done_cnt1  = cnt1_q;
endmodule

// File: tb/tb_alu128_rr_scheduler.sv
// Directed self-checking bench for alu128_rr_scheduler; a second instance with a 2-bit
// counter shares all inputs so counter saturation can be observed.
module tb_alu128_rr_scheduler;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready, req_ready_sat;
  logic [127:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
  logic         req0_mode = 1'b0, req1_mode = 1'b0;
  logic [2:0]   req0_operation = 3'b000, req1_operation = 3'b000;
  logic         resp_valid, resp_valid_sat;
  logic         resp_ready = 1'b0;
  logic         resp_id, resp_id_sat;
  logic [127:0] resp_out, resp_out_sat;
  logic [3:0]   resp_flags, resp_flags_sat;
  logic [15:0]  done_cnt0, done_cnt1;
  logic [1:0]   done_cnt0_sat, done_cnt1_sat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu128_rr_scheduler #(.WIDTH(128), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_mode(req0_mode), .req0_operation(req0_operation),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_mode(req1_mode), .req1_operation(req1_operation),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_out(resp_out),
    .resp_flags(resp_flags), .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
  );

  alu128_rr_scheduler #(.WIDTH(128), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_sat),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_mode(req0_mode), .req0_operation(req0_operation),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_mode(req1_mode), .req1_operation(req1_operation),
    .resp_valid(resp_valid_sat), .resp_ready(resp_ready), .resp_id(resp_id_sat), .resp_out(resp_out_sat),
    .resp_flags(resp_flags_sat), .done_cnt0(done_cnt0_sat), .done_cnt1(done_cnt1_sat)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 2'b00; resp_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic set_req0(input logic [127:0] a, input logic [127:0] b, input logic m, input logic [2:0] o);
    req0_op1 = a; req0_op2 = b; req0_mode = m; req0_operation = o;
  endtask

  task automatic set_req1(input logic [127:0] a, input logic [127:0] b, input logic m, input logic [2:0] o);
    req1_op1 = a; req1_op2 = b; req1_mode = m; req1_operation = o;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 2'b00 || resp_out !== 128'd0 || resp_flags !== 4'd0
        || resp_id !== 1'b0 || done_cnt0 !== 16'd0 || done_cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b ready=%b out=%0h flags=%b id=%b c0=%0d c1=%0d, want all zero",
               resp_valid, req_ready, resp_out, resp_flags, resp_id, done_cnt0, done_cnt1);
    end
    // complete one op so the counter is non-zero, then reset mid-RESP
    set_req0(128'd1, 128'd1, 1'b1, 3'b000);
    req_valid = 2'b01; resp_ready = 1'b1;
    tick(); req_valid = 2'b00; tick(); tick();
    set_req0(128'd9, 128'd9, 1'b1, 3'b000);
    req_valid = 2'b01; resp_ready = 1'b0;
    tick(); req_valid = 2'b00; tick();
    checks++;
    if (resp_valid !== 1'b1 || done_cnt0 !== 16'd1) begin
      errors++;
      $display("FAIL reset_pre_resp: valid=%b c0=%0d, want 1 1", resp_valid, done_cnt0);
    end
    rst = 1'b1; req_valid = 2'b01; resp_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 2'b00 || done_cnt0 !== 16'd0 || resp_out !== 128'd0) begin
      errors++;
      $display("FAIL reset_mid_resp: valid=%b ready=%b c0=%0d out=%0h, want 0 00 0 0",
               resp_valid, req_ready, done_cnt0, resp_out);
    end
    tick();
    rst = 1'b0; req_valid = 2'b00;
    tick();
    checks++;
    if (resp_valid !== 1'b0 || done_cnt0 !== 16'd0) begin
      errors++;
      $display("FAIL reset_after: valid=%b c0=%0d, want 0 0", resp_valid, done_cnt0);
    end
  endtask

  task automatic test_single_op();
    do_reset();
    set_req0(128'd5, 128'd3, 1'b1, 3'b000);
    req_valid = 2'b01; resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL single_ready: got %b want 01", req_ready);
    end
    tick(); req_valid = 2'b00; #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 2'b00) begin
      errors++; $display("FAIL single_exec: valid=%b ready=%b want 0 00", resp_valid, req_ready);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_out !== 128'd8 || resp_id !== 1'b0 || resp_flags !== 4'b0000) begin
      errors++;
      $display("FAIL single_resp: valid=%b out=%0d id=%b flags=%b want 1 8 0 0000",
               resp_valid, resp_out, resp_id, resp_flags);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0 || done_cnt0 !== 16'd1 || done_cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL single_count: valid=%b c0=%0d c1=%0d want 0 1 0", resp_valid, done_cnt0, done_cnt1);
    end
  endtask

  task automatic test_contention();
    logic [127:0] exp_out;
    logic [1:0]   exp_rdy;
    do_reset();
    set_req0(128'd10, 128'd1, 1'b1, 3'b000);
    set_req1(128'd20, 128'd2, 1'b1, 3'b001);
    req_valid = 2'b11; resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL contend_first: got %b want 01", req_ready);
    end
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 2'b00) begin
        errors++; $display("FAIL contend_exec%0d: valid=%b ready=%b want 0 00", k, resp_valid, req_ready);
      end
      tick();
      if (k == 3) req_valid = 2'b00;
      #1;
      exp_out = (k % 2 == 0) ? 128'd11 : 128'd18;
      exp_rdy = (k == 3) ? 2'b00 : ((k % 2 == 0) ? 2'b10 : 2'b01);
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== k[0] || resp_out !== exp_out || req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL contend_resp%0d: valid=%b id=%b out=%0d ready=%b want 1 %b %0d %b",
                 k, resp_valid, resp_id, resp_out, req_ready, k[0], exp_out, exp_rdy);
      end
    end
    tick();
    checks++;
    if (done_cnt0 !== 16'd2 || done_cnt1 !== 16'd2 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL contend_counts: c0=%0d c1=%0d valid=%b want 2 2 0", done_cnt0, done_cnt1, resp_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req0(128'd7, 128'd1, 1'b1, 3'b000);
    set_req1(128'd100, 128'd1, 1'b1, 3'b001);
    req_valid = 2'b01; resp_ready = 1'b0;
    tick(); req_valid = 2'b10; tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_out !== 128'd8 || resp_id !== 1'b0 || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b out=%0d id=%b ready=%b want 1 8 0 00",
                 k, resp_valid, resp_out, resp_id, req_ready);
      end
      tick();
    end
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL bp_release: ready=%b want 10", req_ready);
    end
    tick(); req_valid = 2'b00; tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_out !== 128'd99 || done_cnt0 !== 16'd1) begin
      errors++;
      $display("FAIL bp_req1: valid=%b id=%b out=%0d c0=%0d want 1 1 99 1",
               resp_valid, resp_id, resp_out, done_cnt0);
    end
    tick();
  endtask

  task automatic test_flags();
    logic [127:0] msb_only, max_pos, exp_sum;
    msb_only = {1'b1, 127'd0};
    max_pos  = {1'b0, {127{1'b1}}};
    exp_sum  = {{127{1'b1}}, 1'b0};
    do_reset();
    resp_ready = 1'b1;
    set_req0(msb_only, 128'd0, 1'b1, 3'b101);
    req_valid = 2'b01;
    tick(); req_valid = 2'b00; tick();
    checks++;
    if (resp_out !== 128'd0 || resp_flags !== 4'b1100) begin
      errors++; $display("FAIL flags_shift: out=%0h flags=%b want 0 1100", resp_out, resp_flags);
    end
    tick();
    set_req1(max_pos, max_pos, 1'b1, 3'b000);
    req_valid = 2'b10;
    tick(); req_valid = 2'b00; tick();
    checks++;
    if (resp_out !== exp_sum || resp_flags !== 4'b0011 || resp_id !== 1'b1) begin
      errors++;
      $display("FAIL flags_ovf: out=%0h flags=%b id=%b want %0h 0011 1", resp_out, resp_flags, resp_id, exp_sum);
    end
    tick();
    set_req0(128'hF0, 128'hFF, 1'b0, 3'b010);
    req_valid = 2'b01;
    tick(); req_valid = 2'b00; tick();
    checks++;
    if (resp_out !== 128'h0F || resp_flags !== 4'b0000) begin
      errors++; $display("FAIL flags_xor: out=%0h flags=%b want f 0000", resp_out, resp_flags);
    end
    tick();
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat;
    do_reset();
    resp_ready = 1'b1;
    set_req0(128'd2, 128'd2, 1'b1, 3'b000);
    for (int n = 1; n <= 5; n++) begin
      req_valid = 2'b01;
      tick(); req_valid = 2'b00; tick(); tick();
      exp_sat = (n >= 3) ? 2'd3 : n[1:0];
      checks++;
      if (done_cnt0_sat !== exp_sat || done_cnt0 !== n[15:0]) begin
        errors++;
        $display("FAIL sat_op%0d: sat=%0d wide=%0d want %0d %0d", n, done_cnt0_sat, done_cnt0, exp_sat, n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_flags();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
